// File: rtl/lab1_pkg.sv
// Shared constants and FSM state type for the Lab1 op sequencer.
// Optional feature macro used by this slice: LAB1_SEQ_SUM_EN.
package lab1_pkg;

    localparam int DATA_W  = 3;
    localparam int RES_W   = 8;
    localparam int NUM_OPS = 4;
    localparam int SEL_W   = $clog2(NUM_OPS);
    localparam int SUM_W   = RES_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

endpackage

// File: rtl/lab1_op_sequencer_if.sv
// Operand, ALU and result bundle of the Lab1 op sequencer.
// res_sum exists only when LAB1_SEQ_SUM_EN is defined.
interface lab1_op_sequencer_if;
    import lab1_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_y;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [SEL_W-1:0]  alu_sel;
    logic [RES_W-1:0]  alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [SEL_W-1:0]  res_sel;
    logic [RES_W-1:0]  res_data;
    logic              res_last;
    logic              busy;
`ifdef LAB1_SEQ_SUM_EN
    logic [SUM_W-1:0]  res_sum;

    modport slave (
        input  in_valid, in_x, in_y,
        input  alu_out, res_ready,
        output in_ready, alu_x, alu_y, alu_sel,
        output res_valid, res_sel, res_data,
        output res_last, busy, res_sum
    );

    modport master (
        output in_valid, in_x, in_y,
        output alu_out, res_ready,
        input  in_ready, alu_x, alu_y, alu_sel,
        input  res_valid, res_sel, res_data,
        input  res_last, busy, res_sum
    );
`else
    modport slave (
        input  in_valid, in_x, in_y,
        input  alu_out, res_ready,
        output in_ready, alu_x, alu_y, alu_sel,
        output res_valid, res_sel, res_data,
        output res_last, busy
    );

    modport master (
        output in_valid, in_x, in_y,
        output alu_out, res_ready,
        input  in_ready, alu_x, alu_y, alu_sel,
        input  res_valid, res_sel, res_data,
        input  res_last, busy
    );
`endif

endinterface

// File: rtl/lab1_res_buf.sv
// NUM_OPS x RES_W result store: one write port, async read,
// cleared by the asynchronous reset.
module lab1_res_buf
    import lab1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_idx,
    input  logic [RES_W-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [RES_W-1:0] rd_data
);

    logic [RES_W-1:0] mem [NUM_OPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lab1_op_sequencer.sv
// Sweeps all ALU ops for one operand pair, then streams the results.
// Define LAB1_SEQ_SUM_EN to add the res_sum accumulator output.
module lab1_op_sequencer
    import lab1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    lab1_op_sequencer_if.slave io
);

    state_t            state;
    state_t            state_n;
    logic [SEL_W-1:0]  cnt;
    logic [SEL_W-1:0]  cnt_n;
    logic              in_ready_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] y_q;
    logic              accept;
    logic              last_idx;
    logic              in_drain;
    logic [RES_W-1:0]  rd_data;

    assign last_idx = (cnt == SEL_W'(NUM_OPS - 1));
    assign in_drain = (state == DRAIN);
    assign accept   = (state == IDLE) && io.in_valid
                      && in_ready_q;

    // cnt is the sweep sel and then the drain index; it wraps to 0
    // on the last capture, so DRAIN starts at beat 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SWEEP;
                    cnt_n   = '0;
                end
            end
            SWEEP: begin
                cnt_n = cnt + 1'b1;
                if (last_idx) state_n = DRAIN;
            end
            DRAIN: begin
                if (io.res_ready) begin
                    cnt_n = cnt + 1'b1;
                    if (last_idx) state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            in_ready_q <= (state_n == IDLE);
            if (accept) begin
                x_q <= io.in_x;
                y_q <= io.in_y;
            end
        end
    end

    lab1_res_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (state == SWEEP),
        .wr_idx  (cnt),
        .wr_data (io.alu_out),
        .rd_idx  (cnt),
        .rd_data (rd_data)
    );

    assign io.in_ready  = in_ready_q;
    assign io.alu_x     = x_q;
    assign io.alu_y     = y_q;
    assign io.alu_sel   = (state == SWEEP) ? cnt : '0;
    assign io.res_valid = in_drain;
    assign io.res_sel   = in_drain ? cnt : '0;
    assign io.res_data  = in_drain ? rd_data : '0;
    assign io.res_last  = in_drain && last_idx;
    assign io.busy      = (state != IDLE);

`ifdef LAB1_SEQ_SUM_EN
    logic [SUM_W-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state == SWEEP) begin
            sum_q <= sum_q + SUM_W'(io.alu_out);
        end
    end

    assign io.res_sum = sum_q;
`endif

endmodule

// File: tb/tb_lab1_op_sequencer.sv
// Directed and random bench for lab1_op_sequencer with an ALU stub.
// Checks res_sum too when LAB1_SEQ_SUM_EN is defined.
module tb_lab1_op_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lab1_op_sequencer_if s ();

    lab1_op_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (s)
    );

    assign s.alu_out = {s.alu_sel, s.alu_x, s.alu_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ALU stub result for op s on operands x, y.
    function automatic logic [7:0] beat(
        input int op, input int x, input int y);
        int v;
        v = op * 64 + x * 8 + y;
        return v[7:0];
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait for accept, then follow the sweep.
    task automatic accept(input int x, input int y,
                          input bit keep,
                          input int nx, input int ny);
        int n;
        s.in_x = x[2:0];
        s.in_y = y[2:0];
        s.in_valid = 1'b1;
        n = 0;
        while (!s.in_ready && n < 50) begin
            step();
            n++;
        end
        check("acc_wait", 32'(n < 50), 1);
        step();
        if (keep) begin
            s.in_x = nx[2:0];
            s.in_y = ny[2:0];
        end else begin
            s.in_valid = 1'b0;
        end
        n = 1;
        while (!s.res_valid && n < 50) begin
            check("sweep_sel", s.alu_sel, n - 1);
            check("sweep_rdy", s.in_ready, 0);
            step();
            n++;
        end
        check("latency", n, 5);
        check("alu_x", s.alu_x, x);
        check("alu_y", s.alu_y, y);
    endtask

    // rmode: 0 ready high, 1 pattern 1-0-0, 2 random.
    task automatic drain(input int x, input int y,
                         input int rmode);
        int got;
        int cyc;
        int k;
        bit rdy;
        bit stalled;
        logic [7:0] pdata;
        logic [1:0] psel;
        logic [7:0] exp_q [$];
        int sum;
        sum = 0;
        for (int op = 0; op < 4; op++) begin
            exp_q.push_back(beat(op, x, y));
            sum += beat(op, x, y);
        end
        got = 0;
        cyc = 0;
        k = 0;
        stalled = 1'b0;
        pdata = '0;
        psel = '0;
        while (got < 4 && cyc < 100) begin
            if (rmode == 0) rdy = 1'b1;
            else if (rmode == 1) rdy = (k % 3 == 0);
            else rdy = 1'($urandom_range(0, 1));
            k++;
            s.res_ready = rdy;
            if (s.res_valid) begin
                if (stalled) begin
                    check("hold_data", s.res_data, pdata);
                    check("hold_sel", s.res_sel, psel);
                end
                check("beat_data", s.res_data, exp_q[got]);
                check("beat_sel", s.res_sel, got);
                check("beat_last", s.res_last,
                      32'(got == 3));
                check("drain_rdy", s.in_ready, 0);
`ifdef LAB1_SEQ_SUM_EN
                check("res_sum", s.res_sum, sum);
`endif
                stalled = !rdy;
                pdata = s.res_data;
                psel = s.res_sel;
                if (rdy) got++;
            end
            step();
            cyc++;
        end
        s.res_ready = 1'b0;
        check("beats", got, 4);
        check("post_valid", s.res_valid, 0);
        check("post_busy", s.busy, 0);
        check("post_rdy", s.in_ready, 1);
    endtask

    initial begin
        int nv;
        total = 0;
        bad = 0;
        rst_n = 1'b1;
        s.in_valid = 1'b0;
        s.in_x = '0;
        s.in_y = '0;
        s.res_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        check("rst_rdy", s.in_ready, 0);
        check("rst_ax", s.alu_x, 0);
        check("rst_ay", s.alu_y, 0);
        check("rst_sel", s.alu_sel, 0);
        check("rst_val", s.res_valid, 0);
        check("rst_last", s.res_last, 0);
        check("rst_rsel", s.res_sel, 0);
        check("rst_data", s.res_data, 0);
        check("rst_busy", s.busy, 0);
`ifdef LAB1_SEQ_SUM_EN
        check("rst_sum", s.res_sum, 0);
`endif
        rst_n = 1'b1;
        check("rel_rdy", s.in_ready, 0);
        step();
        check("rel_rdy_up", s.in_ready, 1);

        accept(5, 3, 1'b0, 0, 0);
        check("t2_first", s.res_data, 32'h2B);
        drain(5, 3, 0);

        accept(6, 7, 1'b0, 0, 0);
        drain(6, 7, 1);

        accept(7, 2, 1'b1, 5, 3);
        drain(7, 2, 0);
        accept(5, 3, 1'b0, 0, 0);
        drain(5, 3, 0);

        s.in_x = 3'd4;
        s.in_y = 3'd6;
        s.in_valid = 1'b1;
        step();
        s.in_valid = 1'b0;
        step();
        step();
        check("t5_sel", s.alu_sel, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", s.busy, 0);
        check("t5_val", s.res_valid, 0);
        check("t5_ax", s.alu_x, 0);
        check("t5_asel", s.alu_sel, 0);
        check("t5_rdy", s.in_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        s.res_ready = 1'b1;
        nv = 0;
        repeat (6) begin
            step();
            if (s.res_valid) nv++;
        end
        s.res_ready = 1'b0;
        check("t5_nobeat", nv, 0);
        check("t5_rdy_up", s.in_ready, 1);
        accept(1, 1, 1'b0, 0, 0);
        check("t5_first", s.res_data, 32'h09);
        drain(1, 1, 0);

        for (int i = 0; i < 6; i++) begin
            int rx;
            int ry;
            rx = int'($urandom_range(0, 7));
            ry = int'($urandom_range(0, 7));
            accept(rx, ry, 1'b0, 0, 0);
            drain(rx, ry, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
